dice_roll_monitor: RTL and testbench
====================================

DICE_ROLL_MONITOR -- requirements
Module: dice_roll_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-face occurrence counter (4..16).
REQ-002 SHALL have parameter TOT_W, default 16: width of the total-roll counter.
REQ-003 SHALL have parameter STREAK_TGT, default 3: streak length that fires streak_hit (2..7).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port roll_valid  input  1  high while a settled dice result is present; may stay high for many cycles.
REQ-007 SHALL have port dice_in  input  3  face value, legal range 1..6.
REQ-008 SHALL have port clear  input  1  synchronous clear of all statistics.
REQ-009 SHALL have port rd_face  input  3  face selected for readback.
REQ-010 SHALL have port rd_count  output  CNT_W  registered count for rd_face.
REQ-011 SHALL have port total  output  TOT_W  number of accepted rolls.
REQ-012 SHALL have port last_face  output  3  most recent accepted face; 0 = none yet.
REQ-013 SHALL have port err  output  1  sticky flag: an illegal face was sampled.
REQ-014 SHALL have port streak  output  3  current run length of identical faces.
REQ-015 SHALL have port streak_hit  output  1  one-cycle pulse when streak reaches STREAK_TGT.

Function
REQ-016 SHALL register roll_valid and define a roll event as roll_valid=1 with previous sample 0; a held roll_valid yields exactly one event.
REQ-017 SHALL sample dice_in in the event cycle; all updates from that event SHALL be visible on outputs the following cycle.
REQ-018 SHALL, for a legal face F (1..6), increment count[F] and total, set last_face=F.
REQ-019 SHALL saturate every count[F] at 2^CNT_W-1 and total at 2^TOT_W-1; no wrap-around.
REQ-020 SHALL, for an illegal face (0 or 7), set err=1 and leave counts, total, last_face and streak unchanged.
REQ-021 SHALL drive rd_count = count[rd_face] registered, one-cycle latency; rd_face of 0 or 7 SHALL yield rd_count=0.
REQ-022 SHALL, on clear=1, zero all counts, total, last_face, streak, err and rd_count on the next edge.
REQ-023 SHALL give clear priority over a simultaneous event; that event is discarded and not re-detected while roll_valid stays high.
REQ-024 SHALL keep a read of a face updated in the same cycle consistent: rd_count reflects the pre-update value, the new value one cycle later.

Reset
REQ-025 SHALL, while reset=0, asynchronously force: all counts 0, total 0, rd_count 0, last_face 0, err 0, streak 0, streak_hit 0, roll_valid history 0.
REQ-026 SHALL treat roll_valid already high at reset release as a new event on the first clock edge (history is 0).
REQ-027 SHALL, on reset asserted mid-operation, drop any in-flight update with no partial state retained.

Configuration
REQ-028 SHALL provide macro DICE_STREAK_DETECT_EN.
REQ-029 SHALL, with DICE_STREAK_DETECT_EN defined: on an accepted face equal to last_face increment streak (saturate at 7), otherwise set streak=1; pulse streak_hit for one cycle only in the cycle streak transitions to STREAK_TGT.
REQ-030 SHALL, without DICE_STREAK_DETECT_EN: tie streak and streak_hit to 0 and include no streak logic.

Verification
REQ-031 SHALL test: reset, roll_valid pulses with faces 3,3,5 -> count[3]=2, count[5]=1, total=3, last_face=5.
REQ-032 SHALL test: roll_valid held high 10 cycles, dice_in=4 -> count[4]=1, total=1.
REQ-033 SHALL test: event with dice_in=7 -> err=1, total unchanged; then clear -> err=0, all counts 0.
REQ-034 SHALL test: CNT_W=4, 17 events of face 2 -> count[2]=15, total=17.
REQ-035 SHALL test: clear coincident with event of face 6 -> count[6]=0, total=0.
REQ-036 SHALL test (DICE_STREAK_DETECT_EN): faces 1,1,1,1,2 -> streak 1,2,3,4,1; streak_hit single pulse at third event.

Source files
------------

// File: rtl/dice_roll_monitor.sv
// Dice roll statistics: per-face counters, total, last face, sticky error.
// Optional run-length tracking is enabled by defining DICE_STREAK_DETECT_EN.
module dice_roll_monitor #(
  parameter int CNT_W      = 8,
  parameter int TOT_W      = 16,
  parameter int STREAK_TGT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll_valid,
  input  logic [2:0]       dice_in,
  input  logic             clear,
  input  logic [2:0]       rd_face,
  output logic [CNT_W-1:0] rd_count,
  output logic [TOT_W-1:0] total,
  output logic [2:0]       last_face,
  output logic             err,
  output logic [2:0]       streak,
  output logic             streak_hit
);

  if (CNT_W < 4 || CNT_W > 16) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (STREAK_TGT < 2 || STREAK_TGT > 7) begin : g_bad_tgt
    $error("STREAK_TGT out of range");
  end

  logic             rv_q;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [2:0]       lf_q, lf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             evt;
  logic             legal;
  logic             acc;

  assign evt   = roll_valid & ~rv_q;
  assign legal = (dice_in != 3'd0) && (dice_in != 3'd7);
  assign acc   = evt & legal & ~clear;

  always_comb begin
    cnt_d = cnt_q;
    tot_d = tot_q;
    lf_d  = lf_q;
    err_d = err_q;
    rd_d  = '0;
    // Readback uses the pre-update counters.
    for (int i = 0; i < 6; i++) begin
      if (rd_face == 3'(i + 1)) rd_d = cnt_q[i];
    end
    if (clear) begin
      for (int i = 0; i < 6; i++) cnt_d[i] = '0;
      tot_d = '0;
      lf_d  = '0;
      err_d = 1'b0;
      rd_d  = '0;
    end else if (evt) begin
      if (legal) begin
        for (int i = 0; i < 6; i++) begin
          if (dice_in == 3'(i + 1) && cnt_q[i] != '1)
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        if (tot_q != '1) tot_d = tot_q + TOT_W'(1);
        lf_d = dice_in;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rv_q  <= 1'b0;
      cnt_q <= '{default: '0};
      tot_q <= '0;
      lf_q  <= '0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      rv_q  <= roll_valid;
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      lf_q  <= lf_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_count  = rd_q;
  assign total     = tot_q;
  assign last_face = lf_q;
  assign err       = err_q;

`ifdef DICE_STREAK_DETECT_EN
  logic [2:0] stk_q, stk_d;
  logic       hit_q, hit_d;

  always_comb begin
    stk_d = stk_q;
    hit_d = 1'b0;
    if (clear) begin
      stk_d = '0;
    end else if (acc) begin
      if (dice_in == lf_q)
        stk_d = (stk_q == 3'd7) ? 3'd7 : stk_q + 3'd1;
      else
        stk_d = 3'd1;
      hit_d = (stk_d == 3'(STREAK_TGT)) &&
              (stk_q != 3'(STREAK_TGT));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q <= '0;
      hit_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      hit_q <= hit_d;
    end
  end

  assign streak     = stk_q;
  assign streak_hit = hit_q;
`else
  assign streak     = 3'd0;
  assign streak_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dice_roll_monitor.sv
// Scoreboard bench for dice_roll_monitor (CNT_W=4 to reach saturation).
module tb_dice_roll_monitor;

  localparam int CW = 4;
  localparam int TW = 16;
`ifdef DICE_STREAK_DETECT_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          roll_valid = 1'b0;
  logic [2:0]    dice_in = '0;
  logic          clear = 1'b0;
  logic [2:0]    rd_face = '0;
  logic [CW-1:0] rd_count;
  logic [TW-1:0] total;
  logic [2:0]    last_face;
  logic          err;
  logic [2:0]    streak;
  logic          streak_hit;

  dice_roll_monitor #(.CNT_W(CW), .TOT_W(TW), .STREAK_TGT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .roll_valid (roll_valid),
    .dice_in    (dice_in),
    .clear      (clear),
    .rd_face    (rd_face),
    .rd_count   (rd_count),
    .total      (total),
    .last_face  (last_face),
    .err        (err),
    .streak     (streak),
    .streak_hit (streak_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tot;
    logic [2:0]    lf;
    logic          er;
    logic [2:0]    stk;
    logic          hit;
  } exp_t;

  exp_t q[$];
  int   mc[8];
  int   mtot;
  int   mlf;
  bit   merr;
  int   mstk;
  int   nchk = 0;
  int   nerr = 0;

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) mc[i] = 0;
    mtot = 0;
    mlf  = 0;
    merr = 0;
    mstk = 0;
  endfunction

  function automatic void model_roll(int f);
    exp_t e;
    int   ns;
    bit   h;
    h = 0;
    if (f >= 1 && f <= 6) begin
      if (mc[f] < 15) mc[f]++;
      if (mtot < 65535) mtot++;
      if (STK_EN) begin
        ns   = (mlf == f) ? ((mstk < 7) ? mstk + 1 : 7) : 1;
        h    = (ns == 3) && (mstk != 3);
        mstk = ns;
      end
      mlf = f;
    end else begin
      merr = 1;
    end
    e.tot = TW'(mtot);
    e.lf  = 3'(mlf);
    e.er  = merr;
    e.stk = 3'(mstk);
    e.hit = h;
    q.push_back(e);
  endfunction

  task automatic do_roll(int f);
    roll_valid = 1'b0;
    @(posedge clk); #1;
    dice_in    = 3'(f);
    roll_valid = 1'b1;
    @(posedge clk); #1;
    roll_valid = 1'b0;
    model_roll(f);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (total !== '0 || last_face !== 3'd0 || err !== 1'b0 ||
        streak !== 3'd0 || streak_hit !== 1'b0 || rd_count !== '0) begin
      nerr++;
      $display("FAIL reset: tot=%0d lf=%0d err=%0b stk=%0d hit=%0b rd=%0d want all 0",
               total, last_face, err, streak, streak_hit, rd_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int   faces[3] = '{3, 3, 5};
    int   rf[3]    = '{3, 5, 0};
    exp_t e;
    foreach (faces[k]) begin
      do_roll(faces[k]);
      e = q.pop_front();
      nchk++;
      if (total !== e.tot || last_face !== e.lf || err !== e.er ||
          streak !== e.stk || streak_hit !== e.hit) begin
        nerr++;
        $display("FAIL basic roll %0d: tot=%0d lf=%0d err=%0b stk=%0d hit=%0b want %0d %0d %0b %0d %0b",
                 faces[k], total, last_face, err, streak, streak_hit,
                 e.tot, e.lf, e.er, e.stk, e.hit);
      end
    end
    foreach (rf[k]) begin
      rd_face = 3'(rf[k]);
      @(posedge clk); #1;
      nchk++;
      if (rd_count !== CW'(mc[rf[k]])) begin
        nerr++;
        $display("FAIL basic read face %0d: got %0d want %0d",
                 rf[k], rd_count, mc[rf[k]]);
      end
    end
  endtask

  task automatic test_held();
    exp_t e;
    do_clear();
    roll_valid = 1'b0;
    @(posedge clk); #1;
    dice_in    = 3'd4;
    roll_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    roll_valid = 1'b0;
    model_roll(4);
    e = q.pop_front();
    nchk++;
    if (total !== e.tot || last_face !== e.lf || err !== e.er) begin
      nerr++;
      $display("FAIL held: tot=%0d lf=%0d err=%0b want %0d %0d %0b",
               total, last_face, err, e.tot, e.lf, e.er);
    end
    rd_face = 3'd4;
    @(posedge clk); #1;
    nchk++;
    if (rd_count !== CW'(1)) begin
      nerr++;
      $display("FAIL held count4: got %0d want 1", rd_count);
    end
  endtask

  task automatic test_illegal();
    int   faces[3] = '{2, 7, 0};
    exp_t e;
    do_clear();
    foreach (faces[k]) begin
      do_roll(faces[k]);
      e = q.pop_front();
      nchk++;
      if (total !== e.tot || last_face !== e.lf || err !== e.er ||
          streak !== e.stk) begin
        nerr++;
        $display("FAIL illegal roll %0d: tot=%0d lf=%0d err=%0b stk=%0d want %0d %0d %0b %0d",
                 faces[k], total, last_face, err, streak,
                 e.tot, e.lf, e.er, e.stk);
      end
    end
    do_clear();
    nchk++;
    if (err !== 1'b0 || total !== '0 || last_face !== 3'd0) begin
      nerr++;
      $display("FAIL clear: err=%0b tot=%0d lf=%0d want 0 0 0",
               err, total, last_face);
    end
    for (int f = 1; f <= 6; f++) begin
      rd_face = 3'(f);
      @(posedge clk); #1;
      nchk++;
      if (rd_count !== '0) begin
        nerr++;
        $display("FAIL clear count%0d: got %0d want 0", f, rd_count);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    do_clear();
    for (int n = 0; n < 17; n++) begin
      do_roll(2);
      e = q.pop_front();
      nchk++;
      if (total !== e.tot || last_face !== e.lf) begin
        nerr++;
        $display("FAIL saturate roll %0d: tot=%0d lf=%0d want %0d %0d",
                 n, total, last_face, e.tot, e.lf);
      end
    end
    rd_face = 3'd2;
    @(posedge clk); #1;
    nchk++;
    if (rd_count !== CW'(15) || total !== TW'(17)) begin
      nerr++;
      $display("FAIL saturate: count2=%0d tot=%0d want 15 17",
               rd_count, total);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    do_roll(1);
    void'(q.pop_front());
    roll_valid = 1'b0;
    @(posedge clk); #1;
    dice_in    = 3'd6;
    roll_valid = 1'b1;
    clear      = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    roll_valid = 1'b0;
    rd_face    = 3'd6;
    @(posedge clk); #1;
    nchk++;
    if (rd_count !== '0 || total !== '0 || last_face !== 3'd0) begin
      nerr++;
      $display("FAIL clear priority: count6=%0d tot=%0d lf=%0d want 0 0 0",
               rd_count, total, last_face);
    end
  endtask

  task automatic test_same_cycle_read();
    do_clear();
    do_roll(3);
    void'(q.pop_front());
    rd_face = 3'd3;
    do_roll(3);
    void'(q.pop_front());
    nchk++;
    if (rd_count !== CW'(1)) begin
      nerr++;
      $display("FAIL same-cycle read: got %0d want 1 (pre-update)", rd_count);
    end
    @(posedge clk); #1;
    nchk++;
    if (rd_count !== CW'(2)) begin
      nerr++;
      $display("FAIL same-cycle read next: got %0d want 2", rd_count);
    end
  endtask

  task automatic test_streak();
    int   faces[5] = '{1, 1, 1, 1, 2};
    int   hits = 0;
    exp_t e;
    do_clear();
    foreach (faces[k]) begin
      do_roll(faces[k]);
      e = q.pop_front();
      if (streak_hit === 1'b1) hits++;
      nchk++;
      if (streak !== e.stk || streak_hit !== e.hit || last_face !== e.lf) begin
        nerr++;
        $display("FAIL streak step %0d: stk=%0d hit=%0b lf=%0d want %0d %0b %0d",
                 k, streak, streak_hit, last_face, e.stk, e.hit, e.lf);
      end
    end
    nchk++;
    if (hits != (STK_EN ? 1 : 0)) begin
      nerr++;
      $display("FAIL streak pulses: got %0d want %0d", hits, STK_EN ? 1 : 0);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    roll_valid = 1'b0;
    @(posedge clk); #1;
    dice_in    = 3'd5;
    roll_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    nchk++;
    if (total !== '0 || last_face !== 3'd0 || streak !== 3'd0) begin
      nerr++;
      $display("FAIL async reset: tot=%0d lf=%0d stk=%0d want 0 0 0",
               total, last_face, streak);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    model_roll(5);
    @(posedge clk); #1;
    roll_valid = 1'b0;
    e = q.pop_front();
    nchk++;
    if (total !== e.tot || last_face !== e.lf || err !== e.er ||
        streak !== e.stk) begin
      nerr++;
      $display("FAIL release event: tot=%0d lf=%0d err=%0b stk=%0d want %0d %0d %0b %0d",
               total, last_face, err, streak, e.tot, e.lf, e.er, e.stk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_illegal();
    test_saturate();
    test_clear_priority();
    test_same_cycle_read();
    test_streak();
    test_reset_midop();
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard leftover: got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
